// File: rtl/mfda_seq_pkg.sv
// Shared state encoding, default parameters and a width helper for the inlet sequencer.
// Flush states exist only when INLET_DISPENSE_SEQ_FLUSH_EN is defined.
package mfda_seq_pkg;

    localparam int unsigned DEF_NUM_INLETS  = 3;
    localparam int unsigned DEF_VOL_W       = 16;
    localparam int unsigned DEF_STEP_DIV    = 8;
    localparam int unsigned DEF_VALVE_DLY   = 4;
    localparam int unsigned DEF_FLUSH_STEPS = 32;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        OPEN        = 3'd1,
        PUMP        = 3'd2,
        CLOSE       = 3'd3,
`ifdef INLET_DISPENSE_SEQ_FLUSH_EN
        FLUSH_OPEN  = 3'd4,
        FLUSH_PUMP  = 3'd5,
        FLUSH_CLOSE = 3'd6,
`endif
        FIN         = 3'd7
    } seq_state_e;

    // Bits needed to hold values 0..n, never less than one.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/inlet_dispense_seq_if.sv
// Control/status bundle between a host and the inlet dispense sequencer.
interface inlet_dispense_seq_if
    import mfda_seq_pkg::*;
#(
    parameter int unsigned NUM_INLETS = DEF_NUM_INLETS,
    parameter int unsigned VOL_W      = DEF_VOL_W
) ();

    logic                        start;
    logic                        abort;
    logic [NUM_INLETS*VOL_W-1:0] vol;
    logic [NUM_INLETS-1:0]       valve_open;
    logic                        flush_valve;
    logic                        pump_step;
    logic                        busy;
    logic                        done;
    logic                        aborted;

    modport master (
        output start, abort, vol,
        input  valve_open, flush_valve, pump_step, busy, done, aborted
    );

    modport slave (
        input  start, abort, vol,
        output valve_open, flush_valve, pump_step, busy, done, aborted
    );

endinterface

// File: rtl/step_pacer.sv
// Pump step pacer: loads a step count, then pulses once every STEP_DIV enabled cycles,
// starting on the first enabled cycle, until the count is exhausted.
module step_pacer
    import mfda_seq_pkg::*;
#(
    parameter int unsigned STEP_DIV = DEF_STEP_DIV,
    parameter int unsigned CNT_W    = DEF_VOL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] cnt,
    output logic             pulse,
    output logic             last
);

    localparam int unsigned DIV_W = cnt_w(STEP_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [CNT_W-1:0] rem_q;

    assign pulse = en && (div_q == '0) && (rem_q != '0);
    assign last  = pulse && (rem_q == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            rem_q <= '0;
        end else if (load) begin
            div_q <= '0;
            rem_q <= cnt;
        end else if (en) begin
            div_q <= (div_q == DIV_W'(STEP_DIV - 1)) ? '0 : div_q + DIV_W'(1);
            if (pulse) rem_q <= rem_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/inlet_dispense_seq.sv
// Sequences inlet valves 0..NUM_INLETS-1: open, pump vol[i] steps, close; optional flush
// pass when INLET_DISPENSE_SEQ_FLUSH_EN is defined. Abort ends in FIN with aborted set.
module inlet_dispense_seq
    import mfda_seq_pkg::*;
#(
    parameter int unsigned NUM_INLETS  = DEF_NUM_INLETS,
    parameter int unsigned VOL_W       = DEF_VOL_W,
    parameter int unsigned STEP_DIV    = DEF_STEP_DIV,
    parameter int unsigned VALVE_DLY   = DEF_VALVE_DLY,
    parameter int unsigned FLUSH_STEPS = DEF_FLUSH_STEPS
) (
    input logic                 clk,
    input logic                 rst_n,
    inlet_dispense_seq_if.slave bus
);

    localparam int unsigned IDX_W = (NUM_INLETS > 1) ? $clog2(NUM_INLETS) : 1;
    localparam int unsigned DLY_W = cnt_w(VALVE_DLY);
    localparam logic [VOL_W-1:0] FLUSH_CNT = VOL_W'(FLUSH_STEPS);
`ifdef INLET_DISPENSE_SEQ_FLUSH_EN
    localparam seq_state_e AFTER_INLETS = FLUSH_OPEN;
`else
    localparam seq_state_e AFTER_INLETS = FIN;
`endif

    seq_state_e                       state_q, state_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [DLY_W-1:0]                 dly_q, dly_d;
    logic                             ab_q, ab_d;
    logic [NUM_INLETS-1:0][VOL_W-1:0] vol_q;
    logic                             vol_ld, in_dly;
    logic                             pace_load, pace_en, pace_pulse, pace_last;
    logic [VOL_W-1:0]                 pace_cnt, cur_vol;
    logic                             last_inlet, dly_end;

    assign cur_vol    = vol_q[idx_q];
    assign last_inlet = (idx_q == IDX_W'(NUM_INLETS - 1));
    assign dly_end    = (dly_q == DLY_W'(VALVE_DLY - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            dly_q   <= '0;
            ab_q    <= 1'b0;
            vol_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dly_q   <= dly_d;
            ab_q    <= ab_d;
            if (vol_ld) vol_q <= bus.vol;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ab_d      = ab_q;
        vol_ld    = 1'b0;
        in_dly    = 1'b0;
        pace_load = 1'b0;
        pace_cnt  = FLUSH_CNT;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = OPEN;
                idx_d   = '0;
                ab_d    = 1'b0;
                vol_ld  = 1'b1;
            end
            // A zero-volume inlet is skipped in a single cycle with its valve kept shut.
            OPEN: if (cur_vol == '0) begin
                if (last_inlet) state_d = AFTER_INLETS;
                else            idx_d   = idx_q + IDX_W'(1);
            end else begin
                in_dly = 1'b1;
                if (dly_end) begin
                    state_d   = PUMP;
                    pace_load = 1'b1;
                    pace_cnt  = cur_vol;
                end
            end
            PUMP: if (pace_last) state_d = CLOSE;
            CLOSE: begin
                in_dly = 1'b1;
                if (dly_end) begin
                    if (last_inlet) state_d = AFTER_INLETS;
                    else begin
                        state_d = OPEN;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end
`ifdef INLET_DISPENSE_SEQ_FLUSH_EN
            FLUSH_OPEN: begin
                in_dly = 1'b1;
                if (dly_end) begin
                    state_d   = FLUSH_PUMP;
                    pace_load = 1'b1;
                end
            end
            FLUSH_PUMP: if (pace_last) state_d = FLUSH_CLOSE;
            FLUSH_CLOSE: begin
                in_dly = 1'b1;
                if (dly_end) state_d = FIN;
            end
`endif
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.abort && (state_q != IDLE) && (state_q != FIN)) begin
            state_d   = FIN;
            ab_d      = 1'b1;
            pace_load = 1'b0;
        end
        dly_d = (in_dly && !dly_end && (state_d == state_q)) ? dly_q + DLY_W'(1) : '0;
    end

    always_comb begin
        bus.valve_open  = '0;
        bus.flush_valve = 1'b0;
        pace_en         = (state_q == PUMP);
        if (((state_q == OPEN) && (cur_vol != '0)) || (state_q == PUMP) || (state_q == CLOSE))
            bus.valve_open[idx_q] = 1'b1;
`ifdef INLET_DISPENSE_SEQ_FLUSH_EN
        bus.flush_valve = (state_q == FLUSH_OPEN) || (state_q == FLUSH_PUMP) || (state_q == FLUSH_CLOSE);
        pace_en         = (state_q == PUMP) || (state_q == FLUSH_PUMP);
`endif
        // Abort suppresses a step that would fall in the same cycle.
        bus.pump_step   = pace_pulse && !bus.abort;
        bus.busy        = (state_q != IDLE);
        bus.done        = (state_q == FIN);
        bus.aborted     = (state_q == FIN) && ab_q;
    end

    step_pacer #(
        .STEP_DIV (STEP_DIV),
        .CNT_W    (VOL_W)
    ) u_pacer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (pace_load),
        .en    (pace_en),
        .cnt   (pace_cnt),
        .pulse (pace_pulse),
        .last  (pace_last)
    );

endmodule

// File: tb/tb_inlet_dispense_seq.sv
// Scoreboard bench for inlet_dispense_seq: expected pump pulses are queued at start and
// matched by a monitor; done timing and abort/reset behaviour are checked per scenario.
module tb_inlet_dispense_seq;

    localparam int NI  = 3;
    localparam int VW  = 16;
    localparam int DIV = 8;
    localparam int DLY = 4;
    localparam int FS  = 32;
`ifdef INLET_DISPENSE_SEQ_FLUSH_EN
    localparam bit FLUSH_ON = 1'b1;
`else
    localparam bit FLUSH_ON = 1'b0;
`endif

    typedef struct {
        logic [NI-1:0] vlv;
        logic          fl;
        int            cyc;
    } pulse_t;

    logic   clk = 1'b0;
    logic   rst_n;
    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    bit     saw_valve = 1'b0;
    pulse_t exp_q[$];
    pulse_t e_m;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    inlet_dispense_seq_if #(.NUM_INLETS(NI), .VOL_W(VW)) bus ();

    inlet_dispense_seq #(
        .NUM_INLETS  (NI),
        .VOL_W       (VW),
        .STEP_DIV    (DIV),
        .VALVE_DLY   (DLY),
        .FLUSH_STEPS (FS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Monitor: valve exclusivity every cycle, and each pump pulse against the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.valve_open != '0) saw_valve = 1'b1;
            checks++;
            if ($countones({bus.valve_open, bus.flush_valve}) > 1) begin
                errors++;
                $display("FAIL valve_onehot: valve_open=%b flush_valve=%b at cycle %0d, need at most one high",
                         bus.valve_open, bus.flush_valve, cyc);
            end
            if (bus.pump_step === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: pulse at cycle %0d valve=%b flush=%b, need no pulse",
                             cyc, bus.valve_open, bus.flush_valve);
                end else begin
                    e_m = exp_q.pop_front();
                    if (bus.valve_open !== e_m.vlv || bus.flush_valve !== e_m.fl || cyc != e_m.cyc) begin
                        errors++;
                        $display("FAIL pulse: got valve=%b flush=%b cycle=%0d, need valve=%b flush=%b cycle=%0d",
                                 bus.valve_open, bus.flush_valve, cyc, e_m.vlv, e_m.fl, e_m.cyc);
                    end
                end
            end
        end
    end

    // Reference timing: open delay, one pulse per DIV cycles, close delay; empty inlets take 1 cycle.
    task automatic push_expect(input logic [NI*VW-1:0] v, input int s, output int done_cyc);
        int t, n;
        pulse_t p;
        t = s + 1;
        for (int i = 0; i < NI; i++) begin
            n = int'(v[i*VW +: VW]);
            if (n == 0) t += 1;
            else begin
                t += DLY;
                for (int k = 0; k < n; k++) begin
                    p.vlv = '0; p.vlv[i] = 1'b1; p.fl = 1'b0; p.cyc = t + k * DIV;
                    exp_q.push_back(p);
                end
                t += 1 + (n - 1) * DIV + DLY;
            end
        end
        if (FLUSH_ON) begin
            t += DLY;
            for (int k = 0; k < FS; k++) begin
                p.vlv = '0; p.fl = 1'b1; p.cyc = t + k * DIV;
                exp_q.push_back(p);
            end
            t += 1 + (FS - 1) * DIV + DLY;
        end
        done_cyc = t;
    endtask

    task automatic kick(input logic [NI*VW-1:0] v, output int s, output int ed);
        logic [63:0] rnd;
        @(posedge clk); #1;
        bus.vol = v; bus.start = 1'b1; s = cyc;
        push_expect(v, s, ed);
        @(posedge clk); #1;
        bus.start = 1'b0;
        rnd = {$urandom, $urandom};
        bus.vol = rnd[NI*VW-1:0];
    endtask

    task automatic wait_done(input int budget, output int dc, output logic ab);
        dc = -1; ab = 1'bx;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                dc = cyc; ab = bus.aborted;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (bus.valve_open !== '0) begin errors++; $display("FAIL reset_valve_open: got %b need 0", bus.valve_open); end
        checks++; if (bus.flush_valve !== 1'b0) begin errors++; $display("FAIL reset_flush_valve: got %b need 0", bus.flush_valve); end
        checks++; if (bus.pump_step !== 1'b0) begin errors++; $display("FAIL reset_pump_step: got %b need 0", bus.pump_step); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b need 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b need 0", bus.done); end
        checks++; if (bus.aborted !== 1'b0) begin errors++; $display("FAIL reset_aborted: got %b need 0", bus.aborted); end
        @(posedge clk); #1; rst_n = 1'b1;
    endtask

    task automatic test_dispense(input string name, input logic [NI*VW-1:0] v);
        int s, ed, dc;
        logic ab;
        kick(v, s, ed);
        wait_done(ed - cyc + 20, dc, ab);
        checks++;
        if (dc != ed) begin errors++; $display("FAIL %s done_cycle: got %0d need %0d (cycles after start)", name, dc - s, ed - s); end
        checks++;
        if (ab !== 1'b0) begin errors++; $display("FAIL %s aborted: got %b need 0", name, ab); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL %s missing_pulses: got %0d left need 0", name, exp_q.size()); end
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL %s after_done: got done=%b busy=%b need 0 0", name, bus.done, bus.busy);
        end
    endtask

    task automatic test_all_zero();
        saw_valve = 1'b0;
        test_dispense("all_zero", '0);
        checks++;
        if (saw_valve !== 1'b0) begin errors++; $display("FAIL all_zero_valve: got valve activity need none"); end
    endtask

    // Abort on the cycle of pulse n+1 of inlet 0 (n pulses already seen).
    task automatic test_abort(input string name, input logic [NI*VW-1:0] v, input int n);
        int s, ac;
        pulse_t p;
        @(posedge clk); #1;
        bus.vol = v; bus.start = 1'b1; s = cyc;
        for (int k = 0; k < n; k++) begin
            p.vlv = '0; p.vlv[0] = 1'b1; p.fl = 1'b0; p.cyc = s + 1 + DLY + k * DIV;
            exp_q.push_back(p);
        end
        @(posedge clk); #1; bus.start = 1'b0;
        ac = s + 1 + DLY + n * DIV;
        while (cyc < ac) begin @(posedge clk); #1; end
        bus.abort = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.pump_step !== 1'b0) begin errors++; $display("FAIL %s abort_pulse: got %b need 0", name, bus.pump_step); end
        @(posedge clk); #1; bus.abort = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.valve_open !== '0 || bus.flush_valve !== 1'b0) begin
            errors++; $display("FAIL %s abort_valves: got %b/%b need 0/0", name, bus.valve_open, bus.flush_valve);
        end
        checks++;
        if (bus.done !== 1'b1 || bus.aborted !== 1'b1) begin
            errors++; $display("FAIL %s abort_done: got done=%b aborted=%b need 1 1", name, bus.done, bus.aborted);
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL %s abort_missing: got %0d left need 0", name, exp_q.size()); end
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL %s abort_once: got done=%b busy=%b need 0 0", name, bus.done, bus.busy);
        end
    endtask

    task automatic test_abort_idle();
        @(posedge clk); #1; bus.abort = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                errors++; $display("FAIL abort_idle: got busy=%b done=%b need 0 0", bus.busy, bus.done);
            end
        end
        @(posedge clk); #1; bus.abort = 1'b0;
        bus.vol = {16'd1, 16'd1, 16'd1}; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0; bus.abort = 1'b1;
        @(posedge clk); #1; bus.abort = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || bus.aborted !== 1'b1 || bus.valve_open !== '0) begin
            errors++; $display("FAIL abort_open: got done=%b aborted=%b valve=%b need 1 1 000",
                               bus.done, bus.aborted, bus.valve_open);
        end
    endtask

    task automatic test_start_busy();
        int s, ed, dc;
        logic ab;
        kick({16'd1, 16'd2, 16'd1}, s, ed);
        repeat (4) begin
            repeat (6) @(posedge clk);
            #1; bus.vol = {3{16'd5}}; bus.start = 1'b1;
            @(posedge clk); #1; bus.start = 1'b0;
        end
        wait_done(ed - cyc + 20, dc, ab);
        checks++;
        if (dc != ed) begin errors++; $display("FAIL start_busy done_cycle: got %0d need %0d", dc - s, ed - s); end
        checks++;
        if (exp_q.size() != 0 || ab !== 1'b0) begin
            errors++; $display("FAIL start_busy totals: got %0d left aborted=%b need 0 0", exp_q.size(), ab);
        end
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL start_busy idle: got busy=%b need 0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        int s, ed, cnt;
        kick({16'd3, 16'd3, 16'd3}, s, ed);
        while (cyc < s + 1 + DLY + 2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.valve_open, bus.flush_valve, bus.pump_step, bus.busy, bus.done, bus.aborted} !== '0) begin
            errors++; $display("FAIL reset_mid_outputs: got valve=%b fl=%b ps=%b busy=%b done=%b ab=%b need all 0",
                               bus.valve_open, bus.flush_valve, bus.pump_step, bus.busy, bus.done, bus.aborted);
        end
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b1;
        cnt = 0;
        repeat (8) begin @(negedge clk); if (bus.done === 1'b1 || bus.busy === 1'b1) cnt++; end
        checks++;
        if (cnt != 0) begin errors++; $display("FAIL reset_mid_no_done: got %0d busy/done cycles need 0", cnt); end
        test_dispense("after_reset", {16'd1, 16'd0, 16'd2});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.vol = '0;
        test_reset();
        test_dispense("basic", {16'd2, 16'd0, 16'd3});
        test_all_zero();
        test_dispense("last_only", {16'd1, 16'd0, 16'd0});
        test_dispense("ones", {16'd1, 16'd1, 16'd1});
        test_abort("abort_2nd", {16'd2, 16'd0, 16'd3}, 1);
        test_abort("wide_vol", {16'd0, 16'd0, 16'hFFFF}, 3);
        test_abort_idle();
        test_start_busy();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inlet_dispense_seq.md
INLET_DISPENSE_SEQ -- requirements
Module: inlet_dispense_seq

Interface
REQ-001 SHALL have parameter NUM_INLETS, default 3: number of fluid inlets sequenced (soln1..solnN order).
REQ-002 SHALL have parameter VOL_W, default 16: width of per-inlet step-count volume.
REQ-003 SHALL have parameter STEP_DIV, default 8: clock cycles per pump step pulse period (>=2).
REQ-004 SHALL have parameter VALVE_DLY, default 4: cycles between valve open and first pump step, and between last step and valve close.
REQ-005 SHALL have parameter FLUSH_STEPS, default 32: flush step count (used only with the flush feature).
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 start  input  1  one-cycle request to begin a sequence; honoured only in IDLE.
REQ-009 abort  input  1  level; terminates the sequence safely.
REQ-010 vol  input  NUM_INLETS*VOL_W  step counts, inlet 0 in LSBs; sampled on accepted start.
REQ-011 valve_open  output  NUM_INLETS  one-hot-or-zero inlet valve drive.
REQ-012 flush_valve  output  1  flush channel valve drive.
REQ-013 pump_step  output  1  one-cycle pump step pulse.
REQ-014 busy  output  1  high in any state except IDLE.
REQ-015 done  output  1  one-cycle pulse on sequence completion or abort.
REQ-016 aborted  output  1  qualifies done; high with done only when ended by abort.

Function
REQ-017 FSM states SHALL be IDLE, OPEN, PUMP, CLOSE, FLUSH_OPEN, FLUSH_PUMP, FLUSH_CLOSE, FIN.
REQ-018 IDLE + start SHALL latch vol, set inlet index 0, go to OPEN next cycle; start while busy SHALL be ignored.
REQ-019 Inlet with latched vol 0 SHALL be skipped with no valve activity, costing one cycle of index advance.
REQ-020 OPEN SHALL assert valve_open[idx] for VALVE_DLY cycles, then enter PUMP with valve held.
REQ-021 PUMP SHALL emit exactly vol[idx] pump_step pulses, one every STEP_DIV cycles, first pulse on the first PUMP cycle.
REQ-022 CLOSE SHALL hold valve for VALVE_DLY cycles after last pulse, deassert it, then advance idx; after idx NUM_INLETS-1 go to FLUSH_OPEN (feature on) or FIN.
REQ-023 At most one of valve_open/flush_valve SHALL be high in any cycle; pump_step SHALL only pulse while a valve is open.
REQ-024 FIN SHALL pulse done for one cycle and return to IDLE next cycle.
REQ-025 abort in any busy state SHALL within one cycle deassert all valves and pump_step, enter FIN with aborted=1; abort in IDLE SHALL have no effect.
REQ-026 abort and a pump_step due in the same cycle: abort wins, no pulse.
REQ-027 Step and delay counters SHALL be sized so vol = 2^VOL_W-1 completes without wrap.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, valve_open=0, flush_valve=0, pump_step=0, busy=0, done=0, aborted=0, counters 0.
REQ-029 Reset mid-sequence SHALL not emit done; latched vol discarded.

Configuration
REQ-030 Macro INLET_DISPENSE_SEQ_FLUSH_EN defined: after last inlet, run FLUSH_OPEN/FLUSH_PUMP/FLUSH_CLOSE with flush_valve and FLUSH_STEPS pulses, same timing as REQ-020..022.
REQ-031 Macro undefined: flush states absent, flush_valve tied 0, CLOSE of last inlet goes directly to FIN.

Structure
REQ-032 State enum and default parameter constants SHALL live in shared package mfda_seq_pkg.
REQ-033 Step pacing SHALL be one sub-module step_pacer (divider + remaining-count down-counter, outputs pulse and last).

Verification
REQ-034 vol={3,0,2}, STEP_DIV=8, VALVE_DLY=4, flush off -> 3 pulses under valve_open=001, none for inlet 1, 2 under 100; done at cycle count per REQ-018..024.
REQ-035 vol all zero -> no valve or pump activity; done within NUM_INLETS+3 cycles of start.
REQ-036 abort asserted on 2nd pulse cycle of inlet 0 -> no pulse that cycle, valves 0 next cycle, done=aborted=1 once.
REQ-037 start pulsed while busy -> ignored; pulse totals unchanged.
REQ-038 rst_n low during PUMP -> outputs 0 asynchronously, no done; fresh start after release runs normally.
REQ-039 Flush on, FLUSH_STEPS=32, vol={1,1,1} -> 32 pulses under flush_valve after inlet 2 closes, then done; valve one-hot assertion every cycle.
